// File: rtl/sar_search_ctrl.sv
// MSB-first successive-approximation search controller driving an external magnitude comparator.
// Optional feature: define SAR_EARLY_EXIT_EN to finish the search on the first equal compare.
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_g,
  input  logic             cmp_l,
  input  logic             cmp_e,
  output logic [WIDTH-1:0] trial,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             exact,
  output logic             proto_err
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TEST,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] bit_idx;

  logic             bit_set_c;
  logic             code_bad_c;
  logic             finish_c;
  logic [WIDTH-1:0] acc_new_c;
  logic [WIDTH-1:0] trial_next_c;

  // Compare decode: e and g keep the bit, l or no code clears it; anything but one-hot is illegal.
  always_comb begin
    bit_set_c    = cmp_e | cmp_g;
    code_bad_c   = ~((cmp_g ^ cmp_l ^ cmp_e) & ~(cmp_g & cmp_l & cmp_e));
    acc_new_c    = acc | (WIDTH'(bit_set_c) << bit_idx);
    trial_next_c = acc_new_c | (WIDTH'(1) << (bit_idx - IDX_W'(1)));
  end

  // On equality the new acc equals trial, so acc_new_c also serves the early-exit result.
`ifdef SAR_EARLY_EXIT_EN
  assign finish_c = (bit_idx == '0) || cmp_e;
`else
  assign finish_c = (bit_idx == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      bit_idx   <= '0;
      trial     <= '0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      exact     <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc       <= '0;
            bit_idx   <= IDX_W'(WIDTH - 1);
            trial     <= WIDTH'(1) << (WIDTH - 1);
            proto_err <= 1'b0;
            exact     <= 1'b0;
            busy      <= 1'b1;
            state     <= S_TEST;
          end
        end
        S_TEST: begin
          acc <= acc_new_c;
          if (code_bad_c) proto_err <= 1'b1;
          if (cmp_e)      exact     <= 1'b1;
          if (finish_c) begin
            result <= acc_new_c;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            bit_idx <= bit_idx - IDX_W'(1);
            trial   <= trial_next_c;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl: a modelled comparator answers trials, a monitor checks
// every trial and every done against expectations derived from the hidden value.
module tb_sar_search_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         cmp_g, cmp_l, cmp_e;
  logic [W-1:0] trial;
  logic         busy, done;
  logic [W-1:0] result;
  logic         exact, proto_err;

  logic [W-1:0] unknown;
  logic         f_en, f_g, f_l, f_e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int step    = 0;

  typedef struct {
    int   u;
    int   start_cyc;
    int   latency;
    logic exact;
    logic perr;
  } exp_t;

  exp_t exp_q[$];

  sar_search_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_g(cmp_g), .cmp_l(cmp_l), .cmp_e(cmp_e),
    .trial(trial), .busy(busy), .done(done),
    .result(result), .exact(exact), .proto_err(proto_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model with an override hook for illegal codes.
  always_comb begin
    cmp_g = (unknown > trial);
    cmp_l = (unknown < trial);
    cmp_e = (unknown == trial);
    if (f_en) begin
      cmp_g = f_g;
      cmp_l = f_l;
      cmp_e = f_e;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Trial at step k keeps the hidden value's bits above position W-k and sets bit W-k.
  function automatic int exp_trial(input int u, input int k);
    int b;
    b = W - k;
    return ((u >> (b + 1)) << (b + 1)) | (1 << b);
  endfunction

  function automatic int exp_latency(input int u);
`ifdef SAR_EARLY_EXIT_EN
    int j;
    if (u == 0) return W + 1;
    j = 0;
    while (((u >> j) & 1) == 0) j++;
    return (W - j) + 1;
`else
    return W + 1;
`endif
  endfunction

  // Monitor: checks trials while busy, pops and checks one expectation per done pulse.
  always @(negedge clk) begin
    if (rst) begin
      step = 0;
    end else begin
      if (busy) begin
        step++;
        if (exp_q.size() != 0) begin
          if (step <= W) check("trial", int'(trial), exp_trial(exp_q[0].u, step));
          else check("busy_len", step, W);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result", int'(result), e.u);
          check("exact", int'(exact), int'(e.exact));
          check("proto_err", int'(proto_err), int'(e.perr));
          check("latency", cyc - e.start_cyc, e.latency);
          check("busy_at_done", int'(busy), 0);
        end
        step = 0;
      end
    end
  end

  // One search; optional forced compare code at step fstep, optional ignored start pulses.
  task automatic do_search(input int u, input int fstep, input bit reassert);
    exp_t e;
    int t;
    unknown     = W'(u);
    e.u         = u;
    e.start_cyc = cyc;
    e.latency   = exp_latency(u);
    e.exact     = (u != 0);
    e.perr      = (fstep != 0);
    exp_q.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= W + 1; c++) begin
      start = reassert && (c == 3 || c == W + 1);
      f_en  = (c == fstep);
      @(posedge clk); #1;
    end
    start = 1'b0;
    f_en  = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      check("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  initial begin
    int u2;
    int r;
    rst = 1'b1; start = 1'b0; unknown = '0;
    f_en = 1'b0; f_g = 1'b0; f_l = 1'b0; f_e = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_trial", int'(trial), 0);
    check("rst_result", int'(result), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_exact", int'(exact), 0);
    check("rst_proto_err", int'(proto_err), 0);

    do_search(8'hA5, 0, 0);
    do_search(8'h00, 0, 0);
    do_search(8'h80, 0, 0);
    do_search(8'hFF, 0, 0);
    do_search(8'h01, 0, 0);
    repeat (40) do_search($urandom_range(0, 255), 0, 0);

    // Start pulses during TEST and DONE must be ignored.
    u2 = $urandom_range(0, 127) * 2 + 1;
    do_search(u2, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", int'(result), u2);
    check("hold_exact", int'(exact), 1);
    check("idle_busy", int'(busy), 0);

    // Reset in cycle 4 aborts the search without a done pulse.
    u2 = $urandom_range(1, 255);
    unknown = W'(u2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("abort_busy", int'(busy), 0);
    check("abort_trial", int'(trial), 0);
    check("abort_result", int'(result), 0);
    check("abort_done", int'(done), 0);
    repeat (W + 2) @(posedge clk);
    #1;
    check("abort_still_idle", int'(busy), 0);
    do_search(u2, 0, 0);

    // g and l together at step 2 on 0xFF: decoded as g, flagged as illegal.
    f_g = 1'b1; f_l = 1'b1; f_e = 1'b0;
    do_search(8'hFF, 2, 0);
    repeat (4) @(posedge clk);
    #1;
    check("perr_sticky", int'(proto_err), 1);

    // No code asserted on a zero search: decoded as l, flagged as illegal.
    f_g = 1'b0; f_l = 1'b0; f_e = 1'b0;
    r = $urandom_range(1, W - 1);
    do_search(8'h00, r, 0);

    // A fresh start clears the sticky flag.
    do_search(8'h5A, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
